// File: rtl/nkmd_prog_loader_pkg.sv
// Shared constants for the program loader: FSM state codes, error codes
// and the default frame start marker.
package nkmd_prog_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CNT_HI = 3'd1;
  localparam state_t ST_CNT_LO = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_CSUM   = 3'd4;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_CSUM    = 2'd1;
  localparam err_code_t ERR_COUNT   = 2'd2;
  localparam err_code_t ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h4E;

endpackage

// File: rtl/nkmd_prog_word_asm.sv
// Packs payload bytes little-endian into 32-bit words and keeps the running
// XOR of every byte seen since the last clear.
module nkmd_prog_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic [7:0]  csum
);

  logic [1:0]  lane;
  logic [23:0] low_bytes;

  // Bytes shift in from the top so lane 0 ends up in bits 7:0 after three shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
      csum      <= 8'd0;
    end else if (clear) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
      csum      <= 8'd0;
    end else if (byte_valid) begin
      lane      <= lane + 2'd1;
      low_bytes <= {byte_data, low_bytes[23:8]};
      csum      <= csum ^ byte_data;
    end
  end

  assign word_valid = byte_valid && !clear && (lane == 2'd3);
  assign word_data  = {byte_data, low_bytes};

endmodule

// File: rtl/nkmd_prog_loader.sv
// Parses a framed program image from a byte stream, writes it word by word
// into the program ROM and releases the core once the checksum matches.
module nkmd_prog_loader
  import nkmd_prog_loader_pkg::*;
#(
  parameter int         DEPTH     = 1024,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] prog_addr_o,
  output logic [31:0] prog_data_o,
  output logic        prog_ack_o,
  output logic        core_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  state_t      state;
  logic [7:0]  cnt_hi;
  logic [15:0] word_count;
  logic [15:0] word_idx;
  logic [31:0] timer;

  logic        accept;
  logic        asm_clear;
  logic        asm_valid;
  logic        word_valid;
  logic [31:0] word_data;
  logic [7:0]  csum;
  logic        timeout_hit;

  assign accept      = rx_valid_i && rx_ready_o;
  assign busy_o      = (state != ST_IDLE);
  assign asm_clear   = (state == ST_IDLE) && accept && (rx_data_i == SYNC_BYTE);
  assign asm_valid   = (state == ST_DATA) && accept;
  assign timeout_hit = (TIMEOUT != 0) && busy_o && !accept &&
                       ((timer + 32'd1) == 32'(TIMEOUT));

  nkmd_prog_word_asm u_word_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (asm_clear),
    .byte_data  (rx_data_i),
    .byte_valid (asm_valid),
    .word_data  (word_data),
    .word_valid (word_valid),
    .csum       (csum)
  );

  // Counts consecutive busy cycles without an accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= 32'd0;
    end else if (!busy_o || accept || timeout_hit) begin
      timer <= 32'd0;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rx_ready_o  <= 1'b0;
      prog_addr_o <= 32'd0;
      prog_data_o <= 32'd0;
      prog_ack_o  <= 1'b0;
      core_hold_o <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
      cnt_hi      <= 8'd0;
      word_count  <= 16'd0;
      word_idx    <= 16'd0;
    end else begin
      rx_ready_o <= 1'b1;
      prog_ack_o <= 1'b0;
      done_o     <= 1'b0;
      if (timeout_hit) begin
        state      <= ST_IDLE;
        err_o      <= 1'b1;
        err_code_o <= ERR_TIMEOUT;
      end else if (accept) begin
        case (state)
          ST_IDLE: begin
            if (rx_data_i == SYNC_BYTE) begin
              state       <= ST_CNT_HI;
              err_o       <= 1'b0;
              err_code_o  <= ERR_NONE;
              core_hold_o <= 1'b1;
              word_idx    <= 16'd0;
            end
          end
          ST_CNT_HI: begin
            cnt_hi <= rx_data_i;
            state  <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            if ({16'd0, cnt_hi, rx_data_i} > 32'(DEPTH)) begin
              state      <= ST_IDLE;
              err_o      <= 1'b1;
              err_code_o <= ERR_COUNT;
            end else if ({cnt_hi, rx_data_i} == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              word_count <= {cnt_hi, rx_data_i};
              state      <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (word_valid) begin
              prog_ack_o  <= 1'b1;
              prog_addr_o <= {16'd0, word_idx};
              prog_data_o <= word_data;
              word_idx    <= word_idx + 16'd1;
              if ((word_idx + 16'd1) == word_count) begin
                state <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            if (rx_data_i == csum) begin
              done_o      <= 1'b1;
              core_hold_o <= 1'b0;
            end else begin
              err_o      <= 1'b1;
              err_code_o <= ERR_CSUM;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
